// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides and a 4-bit flag set.
// Define ALU_MUL_EN to build the iterative shift-add multiplier for opcode C.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_SRA  = 4'h7;
  localparam logic [3:0] OP_SLTU = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_PASS = 4'hA;
  localparam logic [3:0] OP_NOR  = 4'hB;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
`endif

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             err;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  req_t s1;
  logic s1_valid;
  rsp_t s2;
  logic s2_valid;
  rsp_t alu_rsp;
  rsp_t mul_rsp;
  logic rdy_en;
  logic s2_free, s1_adv, s1_wr;
  logic mul_idle, s1_is_mul, mul_wr;

  assign s2_free  = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free && mul_idle;
  assign s1_wr    = s1_adv && !s1_is_mul;
  // a multiply leaving S1 parks the front end until its result is written
  assign in_ready = rdy_en && mul_idle && (!s1_valid || s1_wr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdy_en <= 1'b0;
    else     rdy_en <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (in_valid && in_ready) begin
      s1_valid <= 1'b1;
      s1       <= '{op: in_op, a: in_a, b: in_b, tag: in_tag};
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // ---------------- single-cycle datapath ----------------
  logic [SW-1:0]       sh;
  logic [WIDTH:0]      add_w, sub_w, sll_w, srl_w;
  logic signed [WIDTH:0] sra_w;
  logic [WIDTH-1:0]    res;
  logic                cy, ov, ill;

  // the extra bit on each shift catches the last bit shifted out
  assign sh    = s1.b[SW-1:0];
  assign add_w = {1'b0, s1.a} + {1'b0, s1.b};
  assign sub_w = {1'b0, s1.a} - {1'b0, s1.b};
  assign sll_w = {1'b0, s1.a} << sh;
  assign srl_w = {s1.a, 1'b0} >> sh;
  assign sra_w = $signed({s1.a, 1'b0}) >>> sh;

  always_comb begin
    res = '0;
    cy  = 1'b0;
    ov  = 1'b0;
    ill = 1'b0;
    case (s1.op)
      OP_ADD: begin
        res = add_w[WIDTH-1:0];
        cy  = add_w[WIDTH];
        ov  = (s1.a[WIDTH-1] == s1.b[WIDTH-1]) && (res[WIDTH-1] != s1.a[WIDTH-1]);
      end
      OP_SUB: begin
        res = sub_w[WIDTH-1:0];
        cy  = sub_w[WIDTH];
        ov  = (s1.a[WIDTH-1] != s1.b[WIDTH-1]) && (res[WIDTH-1] != s1.a[WIDTH-1]);
      end
      OP_AND:  res = s1.a & s1.b;
      OP_OR:   res = s1.a | s1.b;
      OP_XOR:  res = s1.a ^ s1.b;
      OP_SLL: begin
        res = sll_w[WIDTH-1:0];
        cy  = sll_w[WIDTH];
      end
      OP_SRL: begin
        res = srl_w[WIDTH:1];
        cy  = srl_w[0];
      end
      OP_SRA: begin
        res = sra_w[WIDTH:1];
        cy  = sra_w[0];
      end
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, (s1.a < s1.b)};
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(s1.a) < $signed(s1.b))};
      OP_PASS: res = s1.a;
      OP_NOR:  res = ~(s1.a | s1.b);
`ifdef ALU_MUL_EN
      OP_MUL:  ;
`endif
      default: ill = 1'b1;
    endcase
  end

  assign alu_rsp.result = res;
  assign alu_rsp.flags  = ill ? 4'b1000 : {(res == '0), res[WIDTH-1], cy, ov};
  assign alu_rsp.err    = ill;
  assign alu_rsp.tag    = s1.tag;

  // ---------------- optional shift-add multiplier ----------------
`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mst_t;
  mst_t st, st_nx;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SW-1:0]      cnt;
  logic [TAG_W-1:0]   mtag;
  logic               launch;

  assign s1_is_mul = (s1.op == OP_MUL);
  assign launch    = s1_adv && s1_is_mul;
  assign mul_idle  = (st == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx  = st;
    mul_wr = 1'b0;
    case (st)
      IDLE: if (launch) st_nx = BUSY;
      BUSY: if (cnt == SW'(WIDTH-1)) st_nx = DONE;
      DONE: if (s2_free) begin
        mul_wr = 1'b1;
        st_nx  = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      mtag   <= '0;
    end else if (launch) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, s1.a};
      mplier <= s1.b;
      cnt    <= '0;
      mtag   <= s1.tag;
    end else if (st == BUSY) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  assign mul_rsp.result = acc[WIDTH-1:0];
  assign mul_rsp.flags  = {(acc[WIDTH-1:0] == '0), acc[WIDTH-1], (acc[2*WIDTH-1:WIDTH] != '0), 1'b0};
  assign mul_rsp.err    = 1'b0;
  assign mul_rsp.tag    = mtag;
`else
  assign s1_is_mul = 1'b0;
  assign mul_idle  = 1'b1;
  assign mul_wr    = 1'b0;
  assign mul_rsp   = '0;
`endif

  // ---------------- output register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (mul_wr) begin
      s2_valid <= 1'b1;
      s2       <= mul_rsp;
    end else if (s1_wr) begin
      s2_valid <= 1'b1;
      s2       <= alu_rsp;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid  = s2_valid;
  assign out_result = s2.result;
  assign out_tag    = s2.tag;
  assign out_flags  = s2.flags;
  assign out_err    = s2.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe (WIDTH=8) with a queue scoreboard
// fed by an arithmetic reference model.
module tb_alu_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_op = '0;
  logic [7:0] in_a = '0, in_b = '0;
  logic [3:0] in_tag = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_result;
  logic [3:0] out_tag;
  logic [3:0] out_flags;
  logic       out_err;

  alu_pipe #(.WIDTH(8), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] res;
    logic [3:0] fl;
    logic       err;
    logic [3:0] tag;
    int         acc;
    int         lat;
  } exp_t;

  exp_t  q[$];
  exp_t  nxt_exp;
  int    nxt_lat;
  int    ncmp = 0, nfail = 0, cyc = 0;
  string tname = "init";
  bit    last_acc, busy_chk = 0, hold = 0;
  logic [7:0] h_res;
  logic [3:0] h_tag, h_fl;
  logic       h_err;

  task automatic chk(input string what, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s/%s: observed %0h expected %0h", tname, what, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, b, input logic [3:0] tag);
    exp_t e;
    int ua, ub, sa, sb, sh, r;
    bit c, v, il;
    ua = a; ub = b;
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    sh = ub % 8;
    r = 0; c = 0; v = 0; il = 0;
    case (op)
      4'h0: begin r = ua + ub; c = (r > 255); v = (sa + sb > 127) || (sa + sb < -128); end
      4'h1: begin r = ua - ub; c = (ua < ub); v = (sa - sb > 127) || (sa - sb < -128); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: begin r = ua << sh; c = (sh != 0) && (((ua >> (8 - sh)) & 1) == 1); end
      4'h6: begin r = ua >> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'h7: begin r = sa >>> sh; c = (sh != 0) && (((ua >> (sh - 1)) & 1) == 1); end
      4'h8: r = (ua < ub) ? 1 : 0;
      4'h9: r = (sa < sb) ? 1 : 0;
      4'hA: r = ua;
      4'hB: r = ~(ua | ub);
`ifdef ALU_MUL_EN
      4'hC: begin r = ua * ub; c = (r > 255); end
`endif
      default: il = 1;
    endcase
    e.res = il ? 8'h00 : r[7:0];
    e.fl  = il ? 4'b1000 : {(e.res == 8'h00), e.res[7], c, v};
    e.err = il;
    e.tag = tag;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction

  // one clock: check a drained beat, hold stability, then log an accepted beat
  task automatic tick();
    exp_t e;
    #1;
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_result", out_result, h_res);
      chk("hold_tag", out_tag, h_tag);
      chk("hold_flags", out_flags, h_fl);
      chk("hold_err", out_err, h_err);
    end
    hold = out_valid && !out_ready;
    h_res = out_result; h_tag = out_tag; h_fl = out_flags; h_err = out_err;
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        chk("result", out_result, e.res);
        chk("flags", out_flags, e.fl);
        chk("err", out_err, e.err);
        chk("tag", out_tag, e.tag);
        if (e.lat != 0) chk("latency", cyc - e.acc, e.lat);
      end
    end
    if (busy_chk && q.size() != 0 && !out_valid) chk("mul_in_ready", in_ready, 0);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      e = nxt_exp;
      e.acc = cyc;
      e.lat = nxt_lat;
      q.push_back(e);
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while (q.size() != 0 && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    q.delete();
  endtask

  task automatic run_one(input string nm, input logic [3:0] op, input logic [7:0] a, b,
                         input int lat, input logic [7:0] res, input logic [3:0] fl, input logic err);
    int n = 0;
    tname = nm;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = 4'(cyc); out_ready = 1;
    nxt_exp.res = res; nxt_exp.fl = fl; nxt_exp.err = err; nxt_exp.tag = in_tag;
    nxt_lat = lat;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 20);
    chk("accept", last_acc, 1);
    in_valid = 0;
    nxt_lat = 0;
    wait_drain(40);
  endtask

  initial begin
    logic [7:0] ta[6], tb[6];
    int idx, guard, sent;
    logic [3:0] op;
    logic [7:0] a, b;

    // reset state
    tname = "reset";
    repeat (3) @(negedge clk);
    #1;
    chk("out_valid", out_valid, 0);
    chk("out_result", out_result, 0);
    chk("out_tag", out_tag, 0);
    chk("out_flags", out_flags, 0);
    chk("out_err", out_err, 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    @(negedge clk);

    // directed single operations with literal expectations
    run_one("add_ff_01",  4'h0, 8'hFF, 8'h01, 2, 8'h00, 4'hA, 0);
    run_one("sub_80_01",  4'h1, 8'h80, 8'h01, 2, 8'h7F, 4'h1, 0);
    run_one("sub_01_02",  4'h1, 8'h01, 8'h02, 2, 8'hFF, 4'h6, 0);
    run_one("sra_90_2",   4'h7, 8'h90, 8'h0A, 2, 8'hE4, 4'h4, 0);
    run_one("slt_ff_01",  4'h9, 8'hFF, 8'h01, 2, 8'h01, 4'h0, 0);
    run_one("sltu_ff_01", 4'h8, 8'hFF, 8'h01, 2, 8'h00, 4'h8, 0);
    run_one("illegal_e",  4'hE, 8'h12, 8'h34, 2, 8'h00, 4'h8, 1);
    run_one("sll_81_1",   4'h5, 8'h81, 8'h01, 2, 8'h02, 4'h2, 0);
    run_one("srl_01_1",   4'h6, 8'h01, 8'h01, 2, 8'h00, 4'hA, 0);
    run_one("sll_amt0",   4'h5, 8'h80, 8'h08, 2, 8'h80, 4'h4, 0);
    run_one("nor_0f_f0",  4'hB, 8'h0F, 8'hF0, 2, 8'h00, 4'h8, 0);

`ifdef ALU_MUL_EN
    busy_chk = 1;
    run_one("mul_0f_11", 4'hC, 8'h0F, 8'h11, 11, 8'hFF, 4'h4, 0);
    run_one("mul_10_10", 4'hC, 8'h10, 8'h10, 11, 8'h00, 4'hA, 0);
    busy_chk = 0;
`else
    run_one("mul_illegal", 4'hC, 8'h0F, 8'h11, 2, 8'h00, 4'h8, 1);
`endif

    // full throughput: eight back-to-back beats with no backpressure
    tname = "throughput";
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_op = 4'h0;
      in_a = 8'($urandom_range(0, 255)); in_b = 8'($urandom_range(0, 255)); in_tag = 4'(i);
      nxt_exp = model(in_op, in_a, in_b, in_tag);
      tick();
      chk("every_cycle", last_acc, 1);
    end
    in_valid = 0;
    wait_drain(20);

    // backpressure: tags 1..6, consumer stalled for 5 cycles
    tname = "stall";
    for (int i = 0; i < 6; i++) begin
      ta[i] = 8'($urandom_range(0, 255));
      tb[i] = 8'($urandom_range(0, 255));
    end
    idx = 0;
    out_ready = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1; in_op = 4'h0; in_a = ta[idx]; in_b = tb[idx]; in_tag = 4'(idx + 1);
      nxt_exp = model(in_op, in_a, in_b, in_tag);
      #1;
      chk("ready_stall", in_ready, (c < 2));
      tick();
      if (last_acc) idx++;
    end
    chk("held_beats", idx, 2);
    out_ready = 1;
    guard = 0;
    while (idx < 6 && guard < 30) begin
      in_valid = 1; in_op = 4'h0; in_a = ta[idx]; in_b = tb[idx]; in_tag = 4'(idx + 1);
      nxt_exp = model(in_op, in_a, in_b, in_tag);
      tick();
      if (last_acc) idx++;
      guard++;
    end
    in_valid = 0;
    wait_drain(20);

    // randomized stream against the reference model
    tname = "random";
    sent = 0;
    guard = 0;
    while (sent < 300 && guard < 8000) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        op = 4'($urandom_range(0, 15));
        a  = 8'($urandom_range(0, 255));
        b  = 8'($urandom_range(0, 255));
        in_op = op; in_a = a; in_b = b; in_tag = 4'($urandom_range(0, 15));
        nxt_exp = model(op, a, b, in_tag);
        in_valid = 1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      guard++;
      if (last_acc) begin
        in_valid = 0;
        sent++;
      end
    end
    chk("rand_sent", sent, 300);
    in_valid = 0;
    out_ready = 1;
    wait_drain(200);

    // reset in the middle of an operation discards it
    tname = "mid_reset";
    in_valid = 1; in_a = 8'h10; in_b = 8'h10; in_tag = 4'h9;
`ifdef ALU_MUL_EN
    in_op = 4'hC;
`else
    in_op = 4'h0;
`endif
    out_ready = 0;
    nxt_exp = model(in_op, in_a, in_b, in_tag);
    tick();
    chk("accept", last_acc, 1);
    in_valid = 0;
    repeat (3) tick();
    rst = 1;
    #1;
    chk("out_valid", out_valid, 0);
    chk("out_result", out_result, 0);
    chk("out_tag", out_tag, 0);
    chk("out_flags", out_flags, 0);
    chk("out_err", out_err, 0);
    q.delete();
    hold = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    out_ready = 1;
    for (int i = 0; i < 14; i++) begin
      #1;
      chk("no_stale", out_valid, 0);
      tick();
    end
    run_one("add_after_rst", 4'h0, 8'h02, 8'h03, 2, 8'h05, 4'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
